// File: rtl/upsample_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : upsample_frame_packer
// Brief    : Collects a raster-order pixel stream into one flat frame vector
//            for the up-sampling stage, with a FILL/FULL handshake, a
//            delivered-frame counter and a sticky resynchronisation flag.
// Revision : 1.0 - initial release
// ============================================================================
module upsample_frame_packer #(
    parameter int data_i_width  = 2,
    parameter int data_i_height = 2,
    parameter int bitwidth      = 3,
    localparam int N            = data_i_width * data_i_height,
    localparam int CW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [bitwidth-1:0]     pix_i,
    input  logic                    pix_valid_i,
    input  logic                    sof_i,
    output logic                    pix_ready_o,
    output logic [N*bitwidth-1:0]   frame_o,
    output logic                    frame_valid_o,
    input  logic                    frame_ready_i,
    output logic [15:0]             frame_cnt_o,
    output logic                    sync_err_o
);

    typedef enum logic [0:0] {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    localparam logic [CW-1:0] c_last_slot = CW'(N - 1);

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [N*bitwidth-1:0]  r_frame;
    logic                   r_frame_valid;
    logic [15:0]            r_frame_cnt;
    logic                   r_sync_err;

    logic                   w_accept;
    logic [CW-1:0]          w_slot;
    logic                   w_last;

    // A start-of-frame pixel always lands in slot 0; otherwise it goes to the
    // slot given by the running count.
    always_comb begin
        w_accept = pix_valid_i && (r_state == S_FILL);
        w_slot   = sof_i ? '0 : r_count;
        w_last   = (w_slot == c_last_slot);
    end

    // Frame assembly state machine: fill slots, hold the full frame until
    // downstream takes it, then count the delivery.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_FILL;
            r_count       <= '0;
            r_frame       <= '0;
            r_frame_valid <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_sync_err    <= 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < N; k++) begin
                            if (w_slot == CW'(k)) begin
                                r_frame[k*bitwidth +: bitwidth] <= pix_i;
                            end
                        end
                        // A restart while a frame is partly filled is a
                        // lost-sync event; the stale slots are simply
                        // overwritten by the new frame.
                        if (sof_i && (r_count != '0)) begin
                            r_sync_err <= 1'b1;
                        end
                        if (w_last) begin
                            r_count       <= '0;
                            r_state       <= S_FULL;
                            r_frame_valid <= 1'b1;
                        end else begin
                            r_count <= w_slot + CW'(1);
                        end
                    end
                end
                S_FULL: begin
                    if (frame_ready_i) begin
                        r_state       <= S_FILL;
                        r_frame_valid <= 1'b0;
                        r_frame_cnt   <= r_frame_cnt + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_FILL;
                end
            endcase
        end
    end

    assign pix_ready_o   = (r_state == S_FILL);
    assign frame_o       = r_frame;
    assign frame_valid_o = r_frame_valid;
    assign frame_cnt_o   = r_frame_cnt;
    assign sync_err_o    = r_sync_err;

endmodule
`default_nettype wire

// File: doc/upsample_frame_packer.md
UPSAMPLE_FRAME_PACKER -- requirements
Module: upsample_frame_packer

Interface
REQ-001 SHALL have parameter data_i_width, default 2, meaning pixels per row of the packed frame.
REQ-002 SHALL have parameter data_i_height, default 2, meaning rows per packed frame.
REQ-003 SHALL have parameter bitwidth, default 3, meaning bits per pixel.
REQ-004 SHALL derive local N = data_i_width*data_i_height (pixels per frame) and CW = max(1, clog2(N)) (count width).
REQ-005 SHALL have one clock and a synchronous active-high reset; port: clk  in  1  rising-edge clock.
REQ-006 SHALL have port: rst  in  1  synchronous active-high reset.
REQ-007 SHALL have port: pix_i  in  bitwidth  incoming pixel, raster order.
REQ-008 SHALL have port: pix_valid_i  in  1  pix_i valid.
REQ-009 SHALL have port: sof_i  in  1  start-of-frame marker, qualified by pix_valid_i.
REQ-010 SHALL have port: pix_ready_o  out  1  packer can accept a pixel.
REQ-011 SHALL have port: frame_o  out  N*bitwidth  packed frame, the flat input vector of the up-sampling stage.
REQ-012 SHALL have port: frame_valid_o  out  1  frame_o holds a complete frame.
REQ-013 SHALL have port: frame_ready_i  in  1  downstream consumes frame_o.
REQ-014 SHALL have port: frame_cnt_o  out  16  frames delivered, wraps at 65535->0.
REQ-015 SHALL have port: sync_err_o  out  1  sticky: frame restarted by sof_i mid-fill.

Function
REQ-016 SHALL implement two states, FILL and FULL; pix_ready_o = 1 in FILL, 0 in FULL (combinational from state).
REQ-017 SHALL define pixel accept as pix_valid_i & pix_ready_o on a rising edge.
REQ-018 SHALL write an accepted pixel to frame_o[k*bitwidth +: bitwidth], where k = row*data_i_width + col, i.e. slot = current count.
REQ-019 SHALL, on accept with sof_i=1, write to slot 0 and set count to 1, regardless of the prior count.
REQ-020 SHALL, on accept with sof_i=1 and count != 0, set sync_err_o; the partial frame's remaining slots keep stale data until overwritten.
REQ-021 SHALL, on accept with sof_i=0, write to slot count and increment count; sof_i is optional, and count==0 without sof_i starts a frame without error.
REQ-022 SHALL, when an accept fills slot N-1 (including sof_i with N==1), reset count to 0 and move to FULL with frame_valid_o=1 on the next cycle.
REQ-023 SHALL, in FULL, hold frame_o and frame_valid_o stable until frame_ready_i=1.
REQ-024 SHALL, in FULL with frame_ready_i=1, return to FILL, deassert frame_valid_o, and increment frame_cnt_o (modulo 2^16) on that edge.
REQ-025 SHALL keep frame_valid_o=0 in FILL; frame_o content in FILL is partial and not valid to downstream.
REQ-026 SHALL have a minimum per-frame period of N+1 cycles: one bubble cycle per frame handoff.
REQ-027 SHALL ignore frame_ready_i while in FILL.
REQ-028 SHALL ignore pix_i and sof_i while pix_ready_o=0, with no state change.

Reset
REQ-029 SHALL, on rst=1 at a clock edge, set state=FILL, count=0, frame_o=0, frame_valid_o=0, frame_cnt_o=0, sync_err_o=0.
REQ-030 SHALL give rst priority over all other inputs; a frame that is partial or held in FULL is discarded without incrementing frame_cnt_o.
REQ-031 SHALL drive pix_ready_o=1 in the first cycle after reset release.
REQ-032 SHALL clear sync_err_o only by reset.

Verification (defaults N=4, bitwidth=3)
REQ-033 SHALL cover: pixels 1,2,3,4 (sof on 1), frame_ready_i=1 -> frame_o=12'h8D1, frame_valid_o high exactly 1 cycle, frame_cnt_o=1, sync_err_o=0.
REQ-034 SHALL cover: same frame with frame_ready_i=0 for 5 cycles -> frame_valid_o held, pix_ready_o=0, frame_o stable at 12'h8D1, then released on ready.
REQ-035 SHALL cover: pixels 5,6 then sof with 1,2,3,4 -> sync_err_o=1, frame_o=12'h8D1, frame_cnt_o=1.
REQ-036 SHALL cover: rst asserted in FULL -> next cycle frame_valid_o=0, frame_o=0, frame_cnt_o=0, pix_ready_o=1.
REQ-037 SHALL cover: continuous valid input of 8 pixels with ready=1 -> 2 frames in 10 cycles with 1 bubble each, frame_cnt_o=2.
REQ-038 SHALL cover: frame_cnt_o preloaded by streaming 65536 frames -> frame_cnt_o wraps to 0.
